vector_cpu_ex: RTL and testbench

- Execute stage of the vector CPU. Sits directly downstream of the fetch/decode stage.
- Captures one decoded bundle per handshake: 4 pixel lanes, 4 constant lanes, control bits, and i/j/n/wom_addr.
- Computes a 4-lane add or fixed-point multiply with pixel saturation.
- Presents results plus write enables to the memory/writeback stage through a valid/ready handshake.

---
 rtl/vector_cpu_ex.sv | 198 +++++++++++++++++++
 tb/tb_vector_cpu_ex.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_cpu_ex.sv
// Execute stage of the vector CPU.
// Accepts one decoded bundle per handshake and computes a 4-lane add or a
// fixed-point multiply, with optional clamping of each lane to 0..255.
// The result goes to the memory/writeback stage through a valid/ready
// handshake.
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high. The producer holds valid and its data stable until that edge.
// The consumer may change ready freely, and ready never waits on valid.
// Upstream, in_valid/in_ready follow this rule. Downstream, out_valid/out_ready
// follow it too: while out_valid is high and out_ready is low, the results,
// flags and forwarded fields do not change.
module vector_cpu_ex #(
  parameter int MUL_LAT = 2,
  parameter int FRAC    = 8,
  parameter int SAT     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        wr_pxl,
  input  logic        wr_pos,
  input  logic        wr_mul_reg,
  input  logic        alu_func,
  input  logic        wr_wom,
  input  logic [31:0] pix_in1,
  input  logic [31:0] pix_in2,
  input  logic [31:0] pix_in3,
  input  logic [31:0] pix_in4,
  input  logic [31:0] cte_in1,
  input  logic [31:0] cte_in2,
  input  logic [31:0] cte_in3,
  input  logic [31:0] cte_in4,
  input  logic [31:0] i,
  input  logic [31:0] j,
  input  logic [31:0] n,
  input  logic [31:0] wom_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res1,
  output logic [31:0] res2,
  output logic [31:0] res3,
  output logic [31:0] res4,
  output logic        we_pxl,
  output logic        wr_pos_pxl,
  output logic        we_mul,
  output logic        wr_mul_pos,
  output logic        we_wom,
  output logic [31:0] wom_addr_out,
  output logic [31:0] i_out,
  output logic [31:0] j_out,
  output logic        last,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [15:0] CNT_LOAD = 16'(MUL_LAT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [15:0]       r_cnt;
  logic              w_accept;
  logic [3:0][31:0]  w_pix;
  logic [3:0][31:0]  w_cte;
  logic [3:0][31:0]  r_pix;
  logic [3:0][31:0]  r_cte;
  logic [3:0][31:0]  r_res;
  logic              r_wr_pxl;
  logic              r_wr_pos;
  logic              r_wr_mul_reg;
  logic              r_wr_wom;
  logic              r_last;
  logic [31:0]       r_wom_addr;
  logic [31:0]       r_i;
  logic [31:0]       r_j;
  logic              w_fire;

  // Add lane: 33-bit sum, optionally clamped to the pixel range
  function automatic logic [31:0] f_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    s = {1'b0, a} + {1'b0, b};
    r = s[31:0];
    if (SAT != 0 && s > 33'd255) r = 32'd255;
    return r;
  endfunction

  // Multiply lane: full 64-bit product, truncating shift, optional clamp
  function automatic logic [31:0] f_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    p = {32'd0, a} * {32'd0, b};
    p = p >> FRAC;
    r = p[31:0];
    if (SAT != 0 && p > 64'd255) r = 32'd255;
    return r;
  endfunction

  assign w_pix    = {pix_in4, pix_in3, pix_in2, pix_in1};
  assign w_cte    = {cte_in4, cte_in3, cte_in2, cte_in1};
  assign w_accept = in_valid & in_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = alu_func ? ST_BUSY : ST_DONE;
      ST_BUSY: if (r_cnt == 16'd1) w_state_nxt = ST_DONE;
      ST_DONE: begin
        if (out_ready) begin
          if (w_accept) w_state_nxt = alu_func ? ST_BUSY : ST_DONE;
          else          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state: handshake signals and one-shot strobes
  always_comb begin
    in_ready   = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready);
    out_valid  = (r_state == ST_DONE);
    w_fire     = out_valid & out_ready;
    we_pxl     = w_fire & r_wr_pxl & ~r_wr_mul_reg;
    we_mul     = w_fire & r_wr_mul_reg;
    wr_pos_pxl = w_fire & r_wr_pos & ~r_wr_mul_reg;
    wr_mul_pos = w_fire & r_wr_pos & r_wr_mul_reg;
    we_wom     = w_fire & r_wr_wom;
    dbg_state  = r_state;
  end

  // Multiply latency counter, loaded on a multiply accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 16'd0;
    end else if (w_accept && alu_func) begin
      r_cnt <= CNT_LOAD;
    end else if (r_state == ST_BUSY) begin
      r_cnt <= r_cnt - 16'd1;
    end
  end

  // Bundle capture on accept. Add results are produced right away. Multiply
  // results are written on the last BUSY cycle from the captured operands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pix        <= '0;
      r_cte        <= '0;
      r_res        <= '0;
      r_wr_pxl     <= 1'b0;
      r_wr_pos     <= 1'b0;
      r_wr_mul_reg <= 1'b0;
      r_wr_wom     <= 1'b0;
      r_last       <= 1'b0;
      r_wom_addr   <= 32'd0;
      r_i          <= 32'd0;
      r_j          <= 32'd0;
    end else if (w_accept) begin
      r_pix        <= w_pix;
      r_cte        <= w_cte;
      r_wr_pxl     <= wr_pxl;
      r_wr_pos     <= wr_pos;
      r_wr_mul_reg <= wr_mul_reg;
      r_wr_wom     <= wr_wom;
      r_last       <= (n != 32'd0) && (i == n - 32'd1) && (j == n - 32'd1);
      r_wom_addr   <= wom_addr;
      r_i          <= i;
      r_j          <= j;
      if (!alu_func) begin
        for (int k = 0; k < 4; k++) r_res[k] <= f_add(w_pix[k], w_cte[k]);
      end
    end else if (r_state == ST_BUSY && r_cnt == 16'd1) begin
      for (int k = 0; k < 4; k++) r_res[k] <= f_mul(r_pix[k], r_cte[k]);
    end
  end

  assign res1         = r_res[0];
  assign res2         = r_res[1];
  assign res3         = r_res[2];
  assign res4         = r_res[3];
  assign last         = r_last;
  assign wom_addr_out = r_wom_addr;
  assign i_out        = r_i;
  assign j_out        = r_j;

endmodule

// File: tb/tb_vector_cpu_ex.sv
// Directed bench for the vector CPU execute stage.
// dut  : MUL_LAT=2, FRAC=8, SAT=1
// dut4 : MUL_LAT=4, FRAC=8, SAT=0, with its own reset and handshake signals
module tb_vector_cpu_ex;

  logic clk = 1'b0;
  logic rst, rst4;
  logic in_valid, in_valid4, out_ready, out_ready4;
  logic wr_pxl, wr_pos, wr_mul_reg, alu_func, wr_wom;
  logic [31:0] pix1, pix2, pix3, pix4, cte1, cte2, cte3, cte4;
  logic [31:0] i_in, j_in, n_in, wom_addr;

  logic        in_ready, out_valid, we_pxl, wr_pos_pxl, we_mul, wr_mul_pos, we_wom, last;
  logic [31:0] res1, res2, res3, res4, wom_addr_out, i_out, j_out;
  logic [1:0]  dbg_state;

  logic        in_ready4, out_valid4, we_pxl4, wr_pos_pxl4, we_mul4, wr_mul_pos4, we_wom4, last4;
  logic [31:0] res1_4, res2_4, res3_4, res4_4, wom_addr_out4, i_out4, j_out4;
  logic [1:0]  dbg_state4;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  vector_cpu_ex #(.MUL_LAT(2), .FRAC(8), .SAT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .wr_pxl(wr_pxl), .wr_pos(wr_pos), .wr_mul_reg(wr_mul_reg), .alu_func(alu_func), .wr_wom(wr_wom),
    .pix_in1(pix1), .pix_in2(pix2), .pix_in3(pix3), .pix_in4(pix4),
    .cte_in1(cte1), .cte_in2(cte2), .cte_in3(cte3), .cte_in4(cte4),
    .i(i_in), .j(j_in), .n(n_in), .wom_addr(wom_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .res1(res1), .res2(res2), .res3(res3), .res4(res4),
    .we_pxl(we_pxl), .wr_pos_pxl(wr_pos_pxl), .we_mul(we_mul), .wr_mul_pos(wr_mul_pos), .we_wom(we_wom),
    .wom_addr_out(wom_addr_out), .i_out(i_out), .j_out(j_out), .last(last), .dbg_state(dbg_state)
  );

  vector_cpu_ex #(.MUL_LAT(4), .FRAC(8), .SAT(0)) dut4 (
    .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_ready(in_ready4),
    .wr_pxl(wr_pxl), .wr_pos(wr_pos), .wr_mul_reg(wr_mul_reg), .alu_func(alu_func), .wr_wom(wr_wom),
    .pix_in1(pix1), .pix_in2(pix2), .pix_in3(pix3), .pix_in4(pix4),
    .cte_in1(cte1), .cte_in2(cte2), .cte_in3(cte3), .cte_in4(cte4),
    .i(i_in), .j(j_in), .n(n_in), .wom_addr(wom_addr),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .res1(res1_4), .res2(res2_4), .res3(res3_4), .res4(res4_4),
    .we_pxl(we_pxl4), .wr_pos_pxl(wr_pos_pxl4), .we_mul(we_mul4), .wr_mul_pos(wr_mul_pos4), .we_wom(we_wom4),
    .wom_addr_out(wom_addr_out4), .i_out(i_out4), .j_out(j_out4), .last(last4), .dbg_state(dbg_state4)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctrl(input logic alu, input logic wpxl, input logic wpos,
                          input logic wmul, input logic wwom);
    alu_func = alu; wr_pxl = wpxl; wr_pos = wpos; wr_mul_reg = wmul; wr_wom = wwom;
  endtask

  task automatic set_lanes(input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] p3,
                           input logic [31:0] p4, input logic [31:0] c1, input logic [31:0] c2,
                           input logic [31:0] c3, input logic [31:0] c4);
    pix1 = p1; pix2 = p2; pix3 = p3; pix4 = p4;
    cte1 = c1; cte2 = c2; cte3 = c3; cte4 = c4;
  endtask

  task automatic set_idx(input logic [31:0] ii, input logic [31:0] jj, input logic [31:0] nn,
                         input logic [31:0] aa);
    i_in = ii; j_in = jj; n_in = nn; wom_addr = aa;
  endtask

  initial begin
    rst = 1'b0; rst4 = 1'b0;
    in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b0; out_ready4 = 1'b0;
    set_ctrl(0, 0, 0, 0, 0);
    set_lanes(0, 0, 0, 0, 0, 0, 0, 0);
    set_idx(0, 0, 0, 0);
    #12;
    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_res1", res1, 0);
    check("rst_res4", res4, 0);
    check("rst_last", last, 0);
    check("rst_wom_addr", wom_addr_out, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b1; rst4 = 1'b1;
    step();

    // Add with clamping
    set_ctrl(0, 1, 0, 0, 0);
    set_lanes(10, 200, 0, 255, 5, 100, 0, 1);
    set_idx(1, 2, 8, 32'h40);
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("add_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("add_valid", out_valid, 1);
    check("add_res1", res1, 15);
    check("add_res2", res2, 255);
    check("add_res3", res3, 0);
    check("add_res4", res4, 255);
    check("add_we_pxl", we_pxl, 1);
    check("add_we_mul", we_mul, 0);
    check("add_wom_addr", wom_addr_out, 32'h40);
    check("add_i_out", i_out, 1);
    check("add_j_out", j_out, 2);
    step();
    check("add_valid_drop", out_valid, 0);
    check("add_we_pxl_drop", we_pxl, 0);

    // Multiply, latency 2
    set_ctrl(1, 0, 0, 0, 1);
    set_lanes(100, 4, 255, 0, 32'h180, 32'h040, 32'h200, 32'h300);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("mul_busy_in_ready", in_ready, 0);
    check("mul_busy_valid", out_valid, 0);
    step();
    check("mul_valid", out_valid, 1);
    check("mul_res1", res1, 150);
    check("mul_res2", res2, 1);
    check("mul_res3", res3, 255);
    check("mul_res4", res4, 0);
    check("mul_we_wom", we_wom, 1);
    check("mul_we_pxl", we_pxl, 0);
    step();
    check("mul_idle", out_valid, 0);

    // Stall downstream for 3 cycles
    set_ctrl(0, 1, 0, 0, 0);
    set_lanes(1, 2, 3, 4, 10, 20, 30, 40);
    in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("stall_valid", out_valid, 1);
      check("stall_res1", res1, 11);
      check("stall_res4", res4, 44);
      check("stall_in_ready", in_ready, 0);
      check("stall_we_pxl", we_pxl, 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("stall_release_we_pxl", we_pxl, 1);
    check("stall_release_in_ready", in_ready, 1);
    step();
    check("stall_done_valid", out_valid, 0);
    check("stall_done_we_pxl", we_pxl, 0);

    // Back-to-back adds; expected results go through the scoreboard queue
    for (int k = 0; k < 4; k++) begin
      set_lanes(10 * k, 1, 2, 3, k + 1, 1, 1, 1);
      exp_q.push_back(32'(11 * k + 1));
      in_valid = 1'b1;
      step();
      check("b2b_valid", out_valid, 1);
      check("b2b_we_pxl", we_pxl, 1);
      check("b2b_res1", res1, exp_q.pop_front());
    end
    in_valid = 1'b0;
    step();
    check("b2b_end_valid", out_valid, 0);
    check("b2b_queue_empty", exp_q.size(), 0);

    // Routing and last flag
    set_ctrl(0, 1, 1, 1, 0);
    set_lanes(1, 1, 1, 1, 1, 1, 1, 1);
    set_idx(7, 7, 8, 32'h1234);
    in_valid = 1'b1;
    step();
    check("rt_we_mul", we_mul, 1);
    check("rt_wr_mul_pos", wr_mul_pos, 1);
    check("rt_we_pxl", we_pxl, 0);
    check("rt_wr_pos_pxl", wr_pos_pxl, 0);
    check("rt_last", last, 1);
    check("rt_wom_addr", wom_addr_out, 32'h1234);
    set_ctrl(0, 1, 1, 0, 0);
    set_idx(0, 0, 0, 0);
    step();
    in_valid = 1'b0;
    check("rt_last_n0", last, 0);
    check("rt_wr_pos_pxl2", wr_pos_pxl, 1);
    check("rt_we_pxl2", we_pxl, 1);
    set_idx(5, 7, 8, 0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("rt_last_i_not_last", last, 0);
    step();

    // Reset in the middle of a latency-4 multiply
    set_ctrl(1, 1, 1, 0, 1);
    set_lanes(32'h10000, 3, 0, 0, 32'h200, 32'h100, 0, 0);
    set_idx(3, 3, 4, 32'h99);
    in_valid4 = 1'b1; out_ready4 = 1'b1;
    step();
    in_valid4 = 1'b0;
    step();
    rst4 = 1'b0;
    #1;
    check("mrst_valid", out_valid4, 0);
    check("mrst_in_ready", in_ready4, 1);
    check("mrst_state", dbg_state4, 0);
    check("mrst_last", last4, 0);
    check("mrst_wom_addr", wom_addr_out4, 0);
    step();
    rst4 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check("mrst_no_valid", out_valid4, 0);
      check("mrst_no_strobe", {we_pxl4, wr_pos_pxl4, we_wom4}, 0);
    end

    // Latency-4 multiply without clamping
    in_valid4 = 1'b1;
    step();
    in_valid4 = 1'b0;
    for (int c = 1; c < 4; c++) begin
      check("mul4_wait_valid", out_valid4, 0);
      step();
    end
    check("mul4_valid", out_valid4, 1);
    check("mul4_res1", res1_4, 32'h20000);
    check("mul4_res2", res2_4, 3);
    check("mul4_we_wom", we_wom4, 1);
    check("mul4_last", last4, 1);
    step();

    // Add without clamping
    set_ctrl(0, 1, 0, 0, 0);
    set_lanes(300, 32'hFFFF_FFFF, 0, 0, 5, 2, 0, 0);
    in_valid4 = 1'b1;
    step();
    in_valid4 = 1'b0;
    check("add4_valid", out_valid4, 1);
    check("add4_res1", res1_4, 305);
    check("add4_res2_wrap", res2_4, 1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
